score_seq: RTL and testbench
============================

Name: score_seq

Overview:
- Note sequencer directly upstream of the buzzer tone generator.
- The host pushes {note code, duration} entries into an internal FIFO through a valid/ready handshake.
- On each tempo tick the sequencer pops entries and drives the 6-bit music_scale code consumed by the tone generator. Code 0 is rest, 1-7 low, 8-14 mid, 15-21 high.
- Replaces hard-coded score tables with a runtime-loadable score, including pause, flush and underrun reporting.

Parameters:
- CLK_HZ, 50_000_000: system clock frequency in Hz.
- SPEED, 8: tempo ticks per second. Tick period is CLK_HZ/SPEED cycles.
- DEPTH, 16: FIFO entries. Must be a power of 2. AW = log2(DEPTH).
- GAP, 0: articulation. When 1, the final tick of any note lasting 2 or more ticks outputs rest.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. Asynchronous assert, active-low.
- wr_valid  in  1  host entry valid.
- wr_ready  out  1  FIFO can accept an entry.
- wr_note  in  5  note code 0..21.
- wr_len  in  4  duration minus 1, giving 1..16 ticks.
- play  in  1  level; 1 = run, 0 = pause.
- clear  in  1  synchronous flush.
- music_scale  out  6  note code to the tone generator.
- note_start  out  1  one-cycle pulse when a new entry is loaded.
- busy  out  1  FSM is in PLAY.
- underrun  out  1  sticky flag: a note ended with the FIFO empty.
- fill  out  AW+1  FIFO occupancy.

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - Outputs: music_scale=0, note_start=0, busy=0, underrun=0, fill=0, wr_ready=1.
  - Internal: tick counter 0, FIFO pointers 0, FSM in IDLE.
- Tick generator:
  - Counter runs 0..CLK_HZ/SPEED-1 only while play=1.
  - tick is a registered 1-cycle pulse on wrap.
  - While play=0 the counter holds its value.
- FIFO:
  - Entry is 9 bits, {note, len}.
  - Write occurs on wr_valid && wr_ready.
  - wr_ready = !full && !clear, computed from registered full.
  - wr_note values above 21 are stored as 0 (rest).
  - fill is updated the cycle after a push or pop. A simultaneous push and pop leaves fill unchanged.
- FSM, IDLE state:
  - On tick with FIFO non-empty: pop, load note_reg and remain=len, pulse note_start, go to PLAY.
  - On tick with FIFO empty: stay in IDLE, music_scale stays 0.
- FSM, PLAY state:
  - On tick with remain>0: decrement remain.
  - On tick with remain==0 and FIFO non-empty: pop the next entry and load it seamlessly. No rest is inserted and note_start pulses.
  - On tick with remain==0 and FIFO empty: go to IDLE, set music_scale to 0, set underrun=1.
- Output timing:
  - music_scale is registered and changes on the clock edge where tick=1. Each tick interval carries one code.
  - With GAP=1 and len≥1, music_scale becomes 0 on the edge where remain goes from 1 to 0. It is restored on the next load.
- Pause:
  - While play=0, music_scale reads 0 from the next cycle. note_reg, remain and the tick counter are held.
  - On play returning to 1, music_scale shows note_reg (or 0 if in the gap tick) the next cycle.
  - The remaining duration is preserved exactly.
- clear (priority clear > pop > push):
  - Empties the FIFO and drops any same-cycle write.
  - Sets FSM to IDLE, music_scale=0, underrun=0, tick counter 0.
- Mid-operation reset: async reset takes immediate effect regardless of state.

Test Plan:
1. Parameters CLK_HZ=80, SPEED=8 (tick every 10 cycles), GAP=0. Push {17,len1} then {16,len0}, set play=1. Required: music_scale=17 for 20 cycles, then 16 for 10 cycles, then 0. note_start pulses twice, underrun=1, busy drops.
2. GAP=1. Push {13,len3} then {8,len0}. Required: music_scale=13 for 30 cycles, 0 for 10 cycles, then 8 for 10 cycles.
3. play=0. Push 16 entries. Required: fill=16 and wr_ready=0. A 17th write held valid is not accepted. After play=1 and the first pop, wr_ready=1 and fill=15.
4. Set play=0 for 25 cycles midway through a {10,len2} note. Required: music_scale=0 during the pause. Total cycles at code 10 is still 30, and the next note follows with no lost or extra tick.
5. Assert clear while wr_valid=1 and the FSM is in PLAY. Required: next cycle fill=0, music_scale=0, busy=0, underrun=0, and the write is dropped. A subsequent push of wr_note=25 plays as code 0.
6. Assert rst_n low mid-note. Required: all outputs reach reset values immediately, wr_ready=1, and the sequencer replays nothing after release.

Source files
------------

// File: rtl/score_seq_if.sv
// Host-side bus of the score sequencer: entry push handshake, transport
// controls and the outputs seen by the tone generator.
`default_nettype none

interface score_seq_if #(
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic          wr_valid;
  logic          wr_ready;
  logic [4:0]    wr_note;
  logic [3:0]    wr_len;
  logic          play;
  logic          clear;
  logic [5:0]    music_scale;
  logic          note_start;
  logic          busy;
  logic          underrun;
  logic [AW:0]   fill;

  modport master (
    output wr_valid, wr_note, wr_len, play, clear,
    input  wr_ready, music_scale, note_start, busy, underrun, fill
  );

  modport slave (
    input  wr_valid, wr_note, wr_len, play, clear,
    output wr_ready, music_scale, note_start, busy, underrun, fill
  );
endinterface

`default_nettype wire

// File: rtl/score_seq.sv
// Runtime-loadable note sequencer: FIFO of {note,len} entries popped on tempo
// ticks, with pause, flush, optional articulation gap and underrun reporting.
`default_nettype none

module score_seq #(
  parameter int CLK_HZ = 50_000_000,
  parameter int SPEED  = 8,
  parameter int DEPTH  = 16,
  parameter int GAP    = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  score_seq_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int TP = CLK_HZ / SPEED;
  localparam int CW = (TP > 1) ? $clog2(TP) : 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_PLAY = 1'b1
  } state_t;

  logic [CW-1:0] r_cnt;
  logic          r_tick;
  logic [8:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_fill;
  state_t        r_state;
  logic [4:0]    r_note;
  logic [3:0]    r_remain;
  logic          r_multi;
  logic [5:0]    r_scale;
  logic          r_start;
  logic          r_under;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_load;
  logic [4:0]    w_note_in;
  logic [8:0]    w_head;
  state_t        w_state_nx;
  logic [4:0]    w_note_nx;
  logic [3:0]    w_remain_nx;
  logic          w_multi_nx;
  logic          w_under_nx;
  logic [5:0]    w_code;
  logic [5:0]    w_scale_nx;

  // Counter only advances on play cycles, so a pause freezes tempo phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (bus.clear) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (bus.play) begin
      if (r_cnt == CW'(TP - 1)) begin
        r_cnt  <= '0;
        r_tick <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
        r_tick <= 1'b0;
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign w_full       = (r_fill == (AW + 1)'(DEPTH));
  assign w_empty      = (r_fill == '0);
  assign bus.wr_ready = !w_full && !bus.clear;
  assign w_push       = bus.wr_valid && bus.wr_ready;
  assign w_note_in    = (bus.wr_note > 5'd21) ? 5'd0 : bus.wr_note;
  assign w_head       = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {w_note_in, bus.wr_len};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fill <= '0;
    end else if (bus.clear) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fill <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop) begin
        r_fill <= r_fill + 1'b1;
      end else if (!w_push && w_pop) begin
        r_fill <= r_fill - 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_note_nx   = r_note;
    w_remain_nx = r_remain;
    w_multi_nx  = r_multi;
    w_under_nx  = r_under;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    if (r_tick) begin
      if ((r_state == S_PLAY) && (r_remain != 4'd0)) begin
        w_remain_nx = r_remain - 1'b1;
      end else if (!w_empty) begin
        w_pop       = 1'b1;
        w_load      = 1'b1;
        w_state_nx  = S_PLAY;
        w_note_nx   = w_head[8:4];
        w_remain_nx = w_head[3:0];
        w_multi_nx  = (w_head[3:0] != 4'd0);
      end else if (r_state == S_PLAY) begin
        w_state_nx  = S_IDLE;
        w_under_nx  = 1'b1;
      end
    end
    // Gap tick: last tick of a multi-tick note is silenced.
    if ((w_state_nx == S_PLAY) &&
        !((GAP != 0) && w_multi_nx && (w_remain_nx == 4'd0))) begin
      w_code = {1'b0, w_note_nx};
    end else begin
      w_code = 6'd0;
    end
    w_scale_nx = bus.play ? w_code : 6'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_note   <= 5'd0;
      r_remain <= 4'd0;
      r_multi  <= 1'b0;
      r_scale  <= 6'd0;
      r_start  <= 1'b0;
      r_under  <= 1'b0;
    end else if (bus.clear) begin
      r_state  <= S_IDLE;
      r_note   <= 5'd0;
      r_remain <= 4'd0;
      r_multi  <= 1'b0;
      r_scale  <= 6'd0;
      r_start  <= 1'b0;
      r_under  <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_note   <= w_note_nx;
      r_remain <= w_remain_nx;
      r_multi  <= w_multi_nx;
      r_scale  <= w_scale_nx;
      r_start  <= w_load;
      r_under  <= w_under_nx;
    end
  end

  assign bus.music_scale = r_scale;
  assign bus.note_start  = r_start;
  assign bus.busy        = (r_state == S_PLAY);
  assign bus.underrun    = r_under;
  assign bus.fill        = r_fill;

endmodule

`default_nettype wire

// File: tb/tb_score_seq.sv
// Bench for score_seq: two instances (GAP=0 and GAP=1) share one stimulus and
// one queue-based reference model; literal scenario checks pin the model.
`timescale 1ns/1ps
`default_nettype none

module tb_score_seq;
  localparam int DEPTH = 16;
  localparam int TP    = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wv, pl, clr;
  logic [4:0] wn;
  logic [3:0] wl;

  always #5 clk = ~clk;

  score_seq_if #(.DEPTH(DEPTH)) b0 ();
  score_seq_if #(.DEPTH(DEPTH)) b1 ();

  assign b0.wr_valid = wv;
  assign b0.wr_note  = wn;
  assign b0.wr_len   = wl;
  assign b0.play     = pl;
  assign b0.clear    = clr;
  assign b1.wr_valid = wv;
  assign b1.wr_note  = wn;
  assign b1.wr_len   = wl;
  assign b1.play     = pl;
  assign b1.clear    = clr;

  score_seq #(.CLK_HZ(80), .SPEED(8), .DEPTH(DEPTH), .GAP(0)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0));
  score_seq #(.CLK_HZ(80), .SPEED(8), .DEPTH(DEPTH), .GAP(1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of pending entries, play-cycle count toward the
  // next tick, and the number of tick intervals left on the sounding note.
  logic [8:0] q[$];
  int  pc;
  bit  tick_due;
  bit  act;
  int  cur_note, cur_len, left;
  bit  m_under, m_ns;
  int  ms0, ms1;
  int  c0[64];
  int  c1[64];
  int  nsc0;

  task automatic model_reset();
    q.delete();
    pc = 0; tick_due = 0; act = 0; m_under = 0; m_ns = 0;
    ms0 = 0; ms1 = 0; cur_note = 0; cur_len = 0; left = 0;
  endtask

  task automatic model_step();
    bit         tick;
    bit         canpush;
    logic [8:0] e;
    canpush = (q.size() < DEPTH);
    if (clr) begin
      model_reset();
      return;
    end
    tick     = tick_due;
    tick_due = pl && (pc == TP - 1);
    if (pl) pc = (pc + 1) % TP;
    m_ns = 0;
    if (tick) begin
      if (act && left > 1) begin
        left--;
      end else if (q.size() > 0) begin
        e        = q.pop_front();
        act      = 1;
        cur_note = int'(e[8:4]);
        cur_len  = int'(e[3:0]) + 1;
        left     = cur_len;
        m_ns     = 1;
      end else if (act) begin
        act     = 0;
        m_under = 1;
      end
    end
    if (wv && canpush) q.push_back({(wn > 5'd21) ? 5'd0 : wn, wl});
    ms0 = (pl && act) ? cur_note : 0;
    ms1 = (pl && act && !(cur_len >= 2 && left == 1)) ? cur_note : 0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      chk("ms_gap0",    b0.music_scale, ms0);
      chk("ms_gap1",    b1.music_scale, ms1);
      chk("nstart0",    b0.note_start, m_ns);
      chk("nstart1",    b1.note_start, m_ns);
      chk("busy0",      b0.busy, act);
      chk("busy1",      b1.busy, act);
      chk("underrun0",  b0.underrun, m_under);
      chk("underrun1",  b1.underrun, m_under);
      chk("fill0",      b0.fill, q.size());
      chk("fill1",      b1.fill, q.size());
      chk("wr_ready0",  b0.wr_ready, (q.size() < DEPTH) && !clr);
      chk("wr_ready1",  b1.wr_ready, (q.size() < DEPTH) && !clr);
      c0[b0.music_scale]++;
      c1[b1.music_scale]++;
      if (b0.note_start) nsc0++;
      model_step();
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int note, input int len);
    wv = 1'b1; wn = 5'(note); wl = 4'(len);
    step(1);
    wv = 1'b0;
  endtask

  task automatic pulse_clear();
    clr = 1'b1;
    step(1);
    clr = 1'b0;
  endtask

  // sel 0: note_start, 1: busy, 2: music_scale of GAP=0 instance equals code
  task automatic wait_for(input int sel, input int code, input string nm);
    int  n;
    bit  hit;
    n = 0;
    hit = 0;
    while (!hit && n < 80) begin
      case (sel)
        0:       hit = (b0.note_start === 1'b1);
        1:       hit = (b0.busy === 1'b1);
        default: hit = (b0.music_scale === 6'(code));
      endcase
      if (!hit) begin
        step(1);
        n++;
      end
    end
    chk(nm, hit, 1);
  endtask

  int s0[64];
  int s1[64];
  int sn;

  initial begin
    wv = 0; pl = 0; clr = 0; wn = 0; wl = 0;
    for (int i = 0; i < 64; i++) begin c0[i] = 0; c1[i] = 0; end
    nsc0 = 0;
    step(3);
    rst_n = 1'b1;
    chk("rst_ms",       b0.music_scale, 0);
    chk("rst_wr_ready", b0.wr_ready, 1);
    chk("rst_fill",     b0.fill, 0);
    chk("rst_busy",     b0.busy, 0);

    // Seamless two-note sequence, then underrun.
    push(17, 1); push(16, 0);
    s0 = c0; s1 = c1; sn = nsc0;
    pl = 1;
    step(60);
    chk("t1_17_cycles",     c0[17] - s0[17], 20);
    chk("t1_16_cycles",     c0[16] - s0[16], 10);
    chk("t1_note_starts",   nsc0 - sn, 2);
    chk("t1_underrun",      b0.underrun, 1);
    chk("t1_busy_dropped",  b0.busy, 0);
    chk("t1_gap_17_cycles", c1[17] - s1[17], 10);

    // Articulation gap on a 4-tick note.
    pl = 0;
    push(13, 3); push(8, 0);
    s0 = c0; s1 = c1;
    pl = 1;
    step(70);
    chk("t2_gap_13_cycles", c1[13] - s1[13], 30);
    chk("t2_gap_8_cycles",  c1[8] - s1[8], 10);
    chk("t2_nogap_13",      c0[13] - s0[13], 40);

    // Fill to capacity while paused.
    pl = 0;
    pulse_clear();
    chk("t3_clear_underrun", b0.underrun, 0);
    for (int i = 0; i < DEPTH; i++) push((i % 21) + 1, 0);
    chk("t3_fill_full", b0.fill, 16);
    chk("t3_not_ready", b0.wr_ready, 0);
    wv = 1; wn = 5; wl = 0;
    step(3);
    wv = 0;
    chk("t3_17th_dropped", b0.fill, 16);
    pl = 1;
    wait_for(0, 0, "t3_first_pop");
    chk("t3_fill_after_pop",  b0.fill, 15);
    chk("t3_ready_after_pop", b0.wr_ready, 1);

    // Pause in the middle of a 3-tick note.
    pl = 0;
    pulse_clear();
    push(10, 2); push(12, 0);
    s0 = c0; s1 = c1;
    pl = 1;
    wait_for(2, 10, "t4_note_on");
    step(12);
    pl = 0;
    step(2);
    chk("t4_pause_silent", b0.music_scale, 0);
    step(23);
    pl = 1;
    step(60);
    chk("t4_10_cycles",     c0[10] - s0[10], 30);
    chk("t4_12_cycles",     c0[12] - s0[12], 10);
    chk("t4_gap_10_cycles", c1[10] - s1[10], 20);

    // Clear while playing with a same-cycle write.
    push(7, 5);
    wait_for(1, 0, "t5_busy");
    clr = 1; wv = 1; wn = 3; wl = 0;
    step(1);
    clr = 0; wv = 0;
    chk("t5_fill",     b0.fill, 0);
    chk("t5_ms",       b0.music_scale, 0);
    chk("t5_busy",     b0.busy, 0);
    chk("t5_underrun", b0.underrun, 0);
    push(25, 0);
    wait_for(0, 0, "t5_rest_start");
    chk("t5_rest_code", b0.music_scale, 0);
    chk("t5_rest_busy", b0.busy, 1);

    // Asynchronous reset mid-note.
    step(20);
    push(9, 7); push(11, 0); push(12, 0);
    wait_for(1, 0, "t6_busy");
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_ms",       b0.music_scale, 0);
    chk("t6_busy",     b0.busy, 0);
    chk("t6_fill",     b0.fill, 0);
    chk("t6_wr_ready", b0.wr_ready, 1);
    chk("t6_nstart",   b0.note_start, 0);
    chk("t6_underrun", b0.underrun, 0);
    step(2);
    rst_n = 1'b1;
    sn = nsc0;
    step(40);
    chk("t6_no_replay", nsc0 - sn, 0);

    // Randomized traffic: heavy then sparse writes.
    for (int i = 0; i < 3000; i++) begin
      wv  = (i < 1500) ? ($urandom % 2 == 0) : ($urandom % 40 == 0);
      wn  = 5'($urandom % 32);
      wl  = 4'($urandom % 4);
      pl  = ($urandom % 10) != 0;
      clr = ($urandom % 250) == 0;
      step(1);
    end
    wv = 0; clr = 0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
